// File: rtl/hsi_hue_warp.sv
// hsi_hue_warp: pipelined hue warp for the HSI style path.
// Pulls hues toward an anchor hue (dir=0) or pushes them toward the opposite
// hue anchor+HALF (dir=1). Warp strength ramps in and out one step per frame.
// S and I pass through and stay time-aligned with H. Latency is 2 cycles.
//
// Ports:
//   clk, rst              clock, asynchronous active-low reset
//   iValid, iSof          pixel strobe, first pixel of frame (qualified by iValid)
//   iH, iS, iI            input hue / saturation / intensity
//   cfg_en, cfg_dir       warp enable, direction (sampled on SOF beats only)
//   cfg_anchor, cfg_shift anchor hue, target strength shift (1 = strongest)
//   oValid, oSof          delayed strobes
//   oH, oS, oI            warped hue, delayed saturation / intensity
module hsi_hue_warp #(
   parameter int unsigned HW      = 9,
   parameter int unsigned SW      = 8,
   parameter int unsigned IW      = 8,
   parameter int unsigned HUE_MAX = 360
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          iValid,
   input  logic          iSof,
   input  logic [HW-1:0] iH,
   input  logic [SW-1:0] iS,
   input  logic [IW-1:0] iI,
   input  logic          cfg_en,
   input  logic          cfg_dir,
   input  logic [HW-1:0] cfg_anchor,
   input  logic [2:0]    cfg_shift,
   output logic          oValid,
   output logic          oSof,
   output logic [HW-1:0] oH,
   output logic [SW-1:0] oS,
   output logic [IW-1:0] oI
);

   // One extra bit of headroom for hue arithmetic.
   localparam int unsigned DW = HW + 1;
   localparam logic [DW-1:0] HM   = DW'(HUE_MAX);
   localparam logic [DW-1:0] HALF = DW'(HUE_MAX / 2);
   localparam logic [2:0] S_BYPASS = 3'd7;
   localparam logic [2:0] S_WEAK   = 3'd6;

   typedef enum logic [1:0] {
      ST_OFF,
      ST_IN,
      ST_ACTIVE,
      ST_OUT
   } state_e;

   // ------------------------------------------------------------------
   // Strength FSM registers
   // ------------------------------------------------------------------
   state_e        state_q, state_d;
   logic [2:0]    s_q, s_d;
   logic [2:0]    t_q, t_d;
   logic [HW-1:0] a_q, a_d;
   logic          dir_q, dir_d;

   logic          sof_beat_c;
   logic [HW-1:0] anchor_c;
   logic [2:0]    shift_c;
   logic          cfg_diff_c;
   logic [2:0]    s_step_c;

   assign sof_beat_c = iValid & iSof;

   // Out-of-range anchors fold to hue 0.
   assign anchor_c = (DW'(cfg_anchor) >= HM) ? '0 : cfg_anchor;

   // Shift is clamped to 1..6; 7 is reserved internally for bypass.
   always_comb begin
      shift_c = cfg_shift;
      if (cfg_shift == 3'd0) begin
         shift_c = 3'd1;
      end else if (cfg_shift == 3'd7) begin
         shift_c = S_WEAK;
      end
   end

   // A new anchor or direction needs a full fade-out before it is relatched.
   assign cfg_diff_c = (anchor_c != a_q) || (cfg_dir != dir_q);

   // One strength step toward the requested target.
   always_comb begin
      s_step_c = s_q;
      if (s_q > shift_c) begin
         s_step_c = s_q - 3'd1;
      end else if (s_q < shift_c) begin
         s_step_c = s_q + 3'd1;
      end
   end

   // Next-state logic; only SOF beats advance the FSM.
   always_comb begin
      state_d = state_q;
      s_d     = s_q;
      t_d     = t_q;
      a_d     = a_q;
      dir_d   = dir_q;
      if (sof_beat_c) begin
         case (state_q)
            ST_OFF: begin
               if (cfg_en) begin
                  a_d     = anchor_c;
                  dir_d   = cfg_dir;
                  t_d     = shift_c;
                  s_d     = S_WEAK;
                  state_d = (shift_c == S_WEAK) ? ST_ACTIVE : ST_IN;
               end
            end
            // IN and ACTIVE react identically: in ACTIVE with an unchanged
            // target the step is a no-op and the state stays ACTIVE.
            ST_IN, ST_ACTIVE: begin
               if (!cfg_en || cfg_diff_c) begin
                  s_d     = s_q + 3'd1;
                  state_d = (s_q == S_WEAK) ? ST_OFF : ST_OUT;
               end else begin
                  t_d     = shift_c;
                  s_d     = s_step_c;
                  state_d = (s_step_c == shift_c) ? ST_ACTIVE : ST_IN;
               end
            end
            ST_OUT: begin
               s_d     = s_q + 3'd1;
               state_d = (s_q == S_WEAK) ? ST_OFF : ST_OUT;
            end
            default: begin
               state_d = ST_OFF;
               s_d     = S_BYPASS;
            end
         endcase
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_OFF;
         s_q     <= S_BYPASS;
         t_q     <= '0;
         a_q     <= '0;
         dir_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         s_q     <= s_d;
         t_q     <= t_d;
         a_q     <= a_d;
         dir_q   <= dir_d;
      end
   end

   // ------------------------------------------------------------------
   // Stage 1: hue distance from anchor, using post-update FSM values so
   // the SOF pixel already sees the new strength.
   // ------------------------------------------------------------------
   logic [DW-1:0] h_ext_c, a_ext_c, d_c;
   logic          byp_c;

   assign h_ext_c = DW'(iH);
   assign a_ext_c = DW'(a_d);
   assign d_c     = (h_ext_c >= a_ext_c) ? (h_ext_c - a_ext_c)
                                         : (h_ext_c + HM - a_ext_c);
   assign byp_c   = (s_d == S_BYPASS) || (h_ext_c >= HM);

   logic          v1_q, sof1_q, byp1_q, dir1_q;
   logic [DW-1:0] d1_q;
   logic [2:0]    s1_q;
   logic [HW-1:0] a1_q;
   logic [SW-1:0] sat1_q;
   logic [IW-1:0] int1_q;

   // Bypassed pixels carry the raw hue in the distance register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         v1_q   <= 1'b0;
         sof1_q <= 1'b0;
         byp1_q <= 1'b0;
         dir1_q <= 1'b0;
         d1_q   <= '0;
         s1_q   <= '0;
         a1_q   <= '0;
         sat1_q <= '0;
         int1_q <= '0;
      end else begin
         v1_q   <= iValid;
         sof1_q <= sof_beat_c;
         if (iValid) begin
            byp1_q <= byp_c;
            dir1_q <= dir_d;
            d1_q   <= byp_c ? h_ext_c : d_c;
            s1_q   <= s_d;
            a1_q   <= a_d;
            sat1_q <= iS;
            int1_q <= iI;
         end
      end
   end

   // ------------------------------------------------------------------
   // Stage 2: warp the distance and rotate back onto the wheel.
   // ------------------------------------------------------------------
   logic [DW-1:0] dp_c, sum_c, wrap_c;
   logic [HW-1:0] oh_c;

   always_comb begin
      dp_c = d1_q;
      if (!dir1_q) begin
         if (d1_q <= HALF) begin
            dp_c = d1_q - (d1_q >> s1_q);
         end else begin
            dp_c = d1_q + ((HM - d1_q) >> s1_q);
         end
      end else begin
         if (d1_q <= HALF) begin
            dp_c = d1_q + ((HALF - d1_q) >> s1_q);
         end else begin
            dp_c = d1_q - ((d1_q - HALF) >> s1_q);
         end
      end
      sum_c  = dp_c + DW'(a1_q);
      wrap_c = (sum_c >= HM) ? (sum_c - HM) : sum_c;
      oh_c   = byp1_q ? HW'(d1_q) : HW'(wrap_c);
   end

   logic          ov_q, osof_q;
   logic [HW-1:0] oh_q;
   logic [SW-1:0] os_q;
   logic [IW-1:0] oi_q;

   // Output registers; data holds its last value across gaps.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ov_q   <= 1'b0;
         osof_q <= 1'b0;
         oh_q   <= '0;
         os_q   <= '0;
         oi_q   <= '0;
      end else begin
         ov_q   <= v1_q;
         osof_q <= v1_q & sof1_q;
         if (v1_q) begin
            oh_q <= oh_c;
            os_q <= sat1_q;
            oi_q <= int1_q;
         end
      end
   end

   assign oValid = ov_q;
   assign oSof   = osof_q;
   assign oH     = oh_q;
   assign oS     = os_q;
   assign oI     = oi_q;

endmodule

// File: tb/tb_hsi_hue_warp.sv
// Self-checking bench for hsi_hue_warp: directed frames from the test plan
// plus a randomized stream, all checked against a behavioural model.
module tb_hsi_hue_warp;

   localparam int unsigned HW = 9;
   localparam int unsigned SW = 8;
   localparam int unsigned IW = 8;
   localparam int HM   = 360;
   localparam int HALF = HM / 2;

   logic          clk;
   logic          rst;
   logic          iValid, iSof;
   logic [HW-1:0] iH;
   logic [SW-1:0] iS;
   logic [IW-1:0] iI;
   logic          cfg_en, cfg_dir;
   logic [HW-1:0] cfg_anchor;
   logic [2:0]    cfg_shift;
   logic          oValid, oSof;
   logic [HW-1:0] oH;
   logic [SW-1:0] oS;
   logic [IW-1:0] oI;

   hsi_hue_warp #(.HW(HW), .SW(SW), .IW(IW), .HUE_MAX(HM)) dut (
      .clk(clk), .rst(rst),
      .iValid(iValid), .iSof(iSof), .iH(iH), .iS(iS), .iI(iI),
      .cfg_en(cfg_en), .cfg_dir(cfg_dir), .cfg_anchor(cfg_anchor), .cfg_shift(cfg_shift),
      .oValid(oValid), .oSof(oSof), .oH(oH), .oS(oS), .oI(oI)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Model: warp strength, target, latched anchor/dir, on / fading flags.
   int m_s, m_t, m_a, m_dir;
   bit m_on, m_fade;

   task automatic model_reset();
      m_s = 7; m_t = 0; m_a = 0; m_dir = 0; m_on = 0; m_fade = 0;
   endtask

   task automatic model_sof();
      int ca, cs;
      ca = (int'(cfg_anchor) >= HM) ? 0 : int'(cfg_anchor);
      cs = int'(cfg_shift);
      if (cs < 1) cs = 1;
      if (cs > 6) cs = 6;
      if (m_fade) begin
         m_s++;
         if (m_s == 7) m_fade = 0;
      end else if (!m_on) begin
         if (cfg_en) begin
            m_a = ca; m_dir = int'(cfg_dir); m_t = cs; m_s = 6; m_on = 1;
         end
      end else if (!cfg_en || ca != m_a || int'(cfg_dir) != m_dir) begin
         m_s++;
         m_on = 0;
         m_fade = (m_s < 7);
      end else begin
         m_t = cs;
         if (m_s > m_t) m_s--;
         else if (m_s < m_t) m_s++;
      end
   endtask

   function automatic int warp(input int h);
      int d, dp;
      if (h >= HM || m_s == 7) return h;
      d = (h - m_a + HM) % HM;
      if (m_dir == 0) dp = (d <= HALF) ? d - (d >> m_s) : d + ((HM - d) >> m_s);
      else            dp = (d <= HALF) ? d + ((HALF - d) >> m_s) : d - ((d - HALF) >> m_s);
      return (dp + m_a) % HM;
   endfunction

   typedef struct {
      bit v; bit sof; int h; int s; int i;
   } exp_t;
   exp_t q[$];

   task automatic push_idle();
      exp_t e;
      e.v = 0; e.sof = 0; e.h = 0; e.s = 0; e.i = 0;
      q.push_back(e);
   endtask

   task automatic check_out();
      exp_t e;
      e = q.pop_front();
      chk("oValid", int'(oValid), int'(e.v));
      if (e.v) begin
         chk("oSof", int'(oSof), int'(e.sof));
         chk("oH", int'(oH), e.h);
         chk("oS", int'(oS), e.s);
         chk("oI", int'(oI), e.i);
      end
   endtask

   // Drive one cycle; want >= 0 overrides the model with a hand-derived hue.
   task automatic pix(input bit v, input bit sof, input int h, input int s, input int i,
                      input int want);
      exp_t e;
      iValid = v; iSof = sof; iH = HW'(h); iS = SW'(s); iI = IW'(i);
      if (v && sof) model_sof();
      e.v = v; e.sof = v && sof;
      e.h = (want >= 0) ? want : warp(h);
      e.s = s; e.i = i;
      q.push_back(e);
      @(posedge clk);
      @(negedge clk);
      check_out();
   endtask

   task automatic idle();
      pix(0, 0, 0, 0, 0, -1);
   endtask

   int ramp_exp[6] = '{186, 184, 180, 172, 156, 124};

   initial begin
      rst = 1'b0;
      iValid = 0; iSof = 0; iH = '0; iS = '0; iI = '0;
      cfg_en = 0; cfg_dir = 0; cfg_anchor = '0; cfg_shift = 3'd1;
      model_reset();
      #3;
      chk("rst_oValid", int'(oValid), 0);
      chk("rst_oH", int'(oH), 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      push_idle();

      // Warp disabled: pass-through, then reset mid-stream.
      pix(1, 1, 123, 45, 67, 123);
      pix(1, 0, 250, 9, 8, 250);
      pix(1, 0, 311, 1, 2, 311);
      #2 rst = 1'b0;
      #1;
      chk("midrst_oValid", int'(oValid), 0);
      chk("midrst_oSof", int'(oSof), 0);
      chk("midrst_oH", int'(oH), 0);
      chk("midrst_oS", int'(oS), 0);
      chk("midrst_oI", int'(oI), 0);
      @(negedge clk);
      iValid = 0; iSof = 0;
      rst = 1'b1;
      model_reset();
      q.delete();
      push_idle();
      pix(1, 1, 100, 50, 77, 100);
      idle();

      // Ramp-in toward anchor 60 at full strength.
      cfg_en = 1; cfg_anchor = 9'd60; cfg_dir = 0; cfg_shift = 3'd1;
      for (int k = 0; k < 6; k++) begin
         pix(1, 1, 187, 10 + k, 20 + k, ramp_exp[k]);
         if (k == 0) pix(1, 0, 120, 11, 21, 120);
      end
      pix(1, 1, 120, 3, 4, 90);
      pix(1, 0, 0, 5, 6, 30);
      pix(1, 0, 360, 7, 8, 360);
      idle();

      // Anchor change: fade out to bypass, then relatch.
      cfg_anchor = 9'd200;
      for (int k = 0; k < 6; k++) pix(1, 1, 187, k, k, (k == 5) ? 187 : -1);
      pix(1, 1, 327, 1, 1, 326);

      // Push mode around anchor 0.
      cfg_anchor = 9'd0; cfg_dir = 1; cfg_shift = 3'd2;
      for (int k = 0; k < 10; k++) pix(1, 1, int'($urandom_range(0, 359)), k, k, -1);
      pix(1, 1, 20, 1, 2, 60);
      pix(1, 0, 350, 3, 4, 308);
      pix(1, 0, 180, 5, 6, 180);
      pix(1, 0, 360, 7, 8, 360);

      // Boundaries: anchor 400 acts as 0, shift 0 acts as 1, mid-frame cfg ignored.
      cfg_anchor = 9'd400;
      pix(1, 1, 20, 9, 9, 60);
      cfg_shift = 3'd0;
      pix(1, 1, 20, 9, 9, 100);
      cfg_en = 0; cfg_anchor = 9'd90;
      pix(1, 0, 20, 9, 9, 100);
      idle();

      // Random stream with gaps, frames and occasional reconfiguration.
      cfg_en = 1; cfg_dir = 0; cfg_anchor = 9'd30; cfg_shift = 3'd3;
      for (int n = 0; n < 1000; n++) begin
         bit v, sof;
         int h;
         if ($urandom_range(0, 99) == 0) begin
            cfg_en     = ($urandom_range(0, 4) != 0);
            cfg_dir    = 1'($urandom_range(0, 1));
            cfg_anchor = HW'($urandom_range(0, 450));
            cfg_shift  = 3'($urandom_range(0, 7));
         end
         v   = ($urandom_range(0, 3) != 0);
         sof = v && ($urandom_range(0, 11) == 0);
         h   = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 511))
                                            : int'($urandom_range(0, 359));
         if (v) pix(1, sof, h, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), -1);
         else   idle();
      end
      idle();
      idle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
